// File: rtl/sede_pkg.sv
// Shared definitions for the Sobel edge-detector frame host.
// Holds the FSM state encoding, the default frame geometry and timeout, and the
// detector reset polarity used to hold or release the detector.
// Optional feature macro used by this slice: SEDE_HOST_CHKSUM_EN.
package sede_pkg;

  localparam int unsigned IMG_W_DEF   = 32;
  localparam int unsigned IMG_H_DEF   = 32;
  localparam int unsigned N_DEF       = IMG_W_DEF * IMG_H_DEF;
  localparam int unsigned AW_DEF      = $clog2(N_DEF);
  localparam int unsigned TIMEOUT_DEF = 64;

  // Detector reset is active-high: held in IDLE/PREFETCH/DONE, released while streaming.
  localparam logic DET_RST_ON  = 1'b1;
  localparam logic DET_RST_OFF = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // Detector reset level for a given host state.
  function automatic logic det_rst_for(input state_t s);
    return (s == STREAM || s == DRAIN) ? DET_RST_OFF : DET_RST_ON;
  endfunction

endpackage

// File: rtl/sede_result_writer.sv
// Result collector for the frame host.
// Captures every qualified edge byte into result RAM at sequential addresses,
// saturating at N results, and tracks the DRAIN idle timeout.
// With SEDE_HOST_CHKSUM_EN defined it also keeps a mod-2^16 sum of written bytes.
// Ports:
//   clk, rst           clock, async active-high reset
//   clr                accepted start: clears result count (and checksum)
//   cap_en             capture window (STREAM/DRAIN)
//   drain              host is in DRAIN (timeout counting window)
//   edge_valid/_data   detector output
//   res_we/addr/data   registered result RAM write port
//   rcnt_full_c        all N results written
//   timeout_c          this cycle completes TIMEOUT idle DRAIN cycles
//   chksum             (SEDE_HOST_CHKSUM_EN only) running sum of written bytes
module sede_result_writer
  import sede_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          cap_en,
  input  logic          drain,
  input  logic          edge_valid,
  input  logic [7:0]    edge_data,
  output logic          res_we,
  output logic [AW-1:0] res_addr,
  output logic [7:0]    res_data,
  output logic          rcnt_full_c,
  output logic          timeout_c
`ifdef SEDE_HOST_CHKSUM_EN
  ,
  output logic [15:0]   chksum
`endif
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] rcnt;
  logic [TW-1:0] tcnt;
  logic          capture_c;

  // Count compare, not address wrap, so N == 2^AW terminates correctly.
  assign rcnt_full_c = (rcnt == CW'(N));
  assign capture_c   = cap_en && edge_valid && !rcnt_full_c;
  assign timeout_c   = drain && !edge_valid && (tcnt == TW'(TIMEOUT - 1));

  // Result write port and result count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_we   <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
      rcnt     <= '0;
    end else begin
      res_we <= capture_c;
      if (capture_c) begin
        res_addr <= rcnt[AW-1:0];
        res_data <= edge_data;
      end
      if (clr) begin
        rcnt <= '0;
      end else if (capture_c) begin
        rcnt <= rcnt + CW'(1);
      end
    end
  end

  // Consecutive idle cycles while draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (drain && !edge_valid) begin
      tcnt <= tcnt + TW'(1);
    end else begin
      tcnt <= '0;
    end
  end

`ifdef SEDE_HOST_CHKSUM_EN
  // Running sum of every byte written; only moves during capture, so it holds after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chksum <= '0;
    end else if (clr) begin
      chksum <= '0;
    end else if (capture_c) begin
      chksum <= chksum + 16'(edge_data);
    end
  end
`endif

endmodule

// File: rtl/sede_frame_host.sv
// Frame-level driver/collector for the Sobel edge detector.
// On an accepted start, reads one IMG_W x IMG_H frame from image RAM (two reads
// ahead of the pixel stream), feeds the detector one pixel per clock, collects the
// edge bytes into result RAM and reports done, or err on a DRAIN timeout.
// Optional feature macro: SEDE_HOST_CHKSUM_EN adds the chksum output.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    frame request, honoured in IDLE only
//   img_rd/img_addr/img_data image RAM read port (data 1 cycle after img_rd)
//   det_rst/pix_data         detector reset and pixel stream
//   edge_valid/edge_data     detector result stream
//   edge_busy                detector status, not used by the control path
//   res_we/res_addr/res_data result RAM write port
//   busy/done/err            frame status
//   chksum                   (SEDE_HOST_CHKSUM_EN only) sum of written bytes
module sede_frame_host
  import sede_pkg::*;
#(
  parameter int unsigned IMG_W   = IMG_W_DEF,
  parameter int unsigned IMG_H   = IMG_H_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned AW      = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          img_rd,
  output logic [AW-1:0] img_addr,
  input  logic [7:0]    img_data,
  output logic          det_rst,
  output logic [7:0]    pix_data,
  input  logic          edge_valid,
  input  logic [7:0]    edge_data,
  input  logic          edge_busy,
  output logic          res_we,
  output logic [AW-1:0] res_addr,
  output logic [7:0]    res_data,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef SEDE_HOST_CHKSUM_EN
  ,
  output logic [15:0]   chksum
`endif
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned CW = AW + 1;

  state_t        state, nxt;
  logic          pf_cnt, pf_cnt_d;
  logic [CW-1:0] st_cnt, st_cnt_d;
  logic [CW-1:0] rd_cnt, rd_cnt_d;
  logic          img_rd_d, det_rst_d, busy_d, done_d, err_d;
  logic [AW-1:0] img_addr_d;
  logic [7:0]    pix_data_d;
  logic          start_ok_c;
  logic          rcnt_full_c;
  logic          timeout_c;

  // Detector status only; kept for observation.
  logic unused_edge_busy;
  assign unused_edge_busy = edge_busy;

  assign start_ok_c = (state == IDLE) && start;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pf_cnt   <= 1'b0;
      st_cnt   <= '0;
      rd_cnt   <= '0;
      img_rd   <= 1'b0;
      img_addr <= '0;
      pix_data <= '0;
      det_rst  <= DET_RST_ON;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= nxt;
      pf_cnt   <= pf_cnt_d;
      st_cnt   <= st_cnt_d;
      rd_cnt   <= rd_cnt_d;
      img_rd   <= img_rd_d;
      img_addr <= img_addr_d;
      pix_data <= pix_data_d;
      det_rst  <= det_rst_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  // Next-state logic; STREAM always passes through DRAIN.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (start) nxt = PREFETCH;
      PREFETCH: if (pf_cnt) nxt = STREAM;
      STREAM:   if (st_cnt == CW'(N - 1)) nxt = DRAIN;
      DRAIN:    if (rcnt_full_c || timeout_c) nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Output/counter next values, computed from the upcoming state so outputs line up with it.
  always_comb begin
    img_rd_d   = 1'b0;
    img_addr_d = '0;
    rd_cnt_d   = '0;
    pix_data_d = '0;
    pf_cnt_d   = 1'b0;
    st_cnt_d   = '0;
    det_rst_d  = det_rst_for(nxt);
    busy_d     = (nxt == PREFETCH) || (nxt == STREAM) || (nxt == DRAIN);
    done_d     = (nxt == DONE);
    err_d      = err;

    // Reads lead the pixel stream by two cycles and stop after address N-1.
    if (nxt == PREFETCH || nxt == STREAM) begin
      rd_cnt_d = rd_cnt;
      if (rd_cnt != CW'(N)) begin
        img_rd_d   = 1'b1;
        img_addr_d = rd_cnt[AW-1:0];
        rd_cnt_d   = rd_cnt + CW'(1);
      end
    end

    if (nxt == STREAM)     pix_data_d = img_data;
    if (state == PREFETCH) pf_cnt_d   = ~pf_cnt;
    if (state == STREAM)   st_cnt_d   = st_cnt + CW'(1);

    // err is sticky until the next accepted start; a full result set beats a timeout.
    if (start_ok_c) begin
      err_d = 1'b0;
    end else if (state == DRAIN && timeout_c && !rcnt_full_c) begin
      err_d = 1'b1;
    end
  end

  sede_result_writer #(
    .N       (N),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) u_writer (
    .clk         (clk),
    .rst         (rst),
    .clr         (start_ok_c),
    .cap_en      ((state == STREAM) || (state == DRAIN)),
    .drain       (state == DRAIN),
    .edge_valid  (edge_valid),
    .edge_data   (edge_data),
    .res_we      (res_we),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .rcnt_full_c (rcnt_full_c),
    .timeout_c   (timeout_c)
`ifdef SEDE_HOST_CHKSUM_EN
    ,
    .chksum      (chksum)
`endif
  );

endmodule

// File: tb/tb_sede_frame_host.sv
// Directed bench for sede_frame_host: image RAM and detector models, a write/read
// monitor, and a linear sequence of frames with hand-computed expectations.
// Under SEDE_HOST_CHKSUM_EN it also exercises the checksum output.
`timescale 1ns/1ps
module tb_sede_frame_host;

  localparam int unsigned AW = 10;
  localparam int unsigned N  = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          img_rd;
  logic [AW-1:0] img_addr;
  logic [7:0]    img_data = 8'h00;
  logic          det_rst;
  logic [7:0]    pix_data;
  logic          edge_valid = 1'b0;
  logic [7:0]    edge_data = 8'h00;
  logic          edge_busy;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic [7:0]    res_data;
  logic          busy, done, err;
`ifdef SEDE_HOST_CHKSUM_EN
  logic [15:0]   chksum;
`endif

  sede_frame_host dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .img_rd     (img_rd),
    .img_addr   (img_addr),
    .img_data   (img_data),
    .det_rst    (det_rst),
    .pix_data   (pix_data),
    .edge_valid (edge_valid),
    .edge_data  (edge_data),
    .edge_busy  (edge_busy),
    .res_we     (res_we),
    .res_addr   (res_addr),
    .res_data   (res_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef SEDE_HOST_CHKSUM_EN
    ,
    .chksum     (chksum)
`endif
  );

  always #5 clk = ~clk;

  int unsigned img_mode  = 0;   // 0: ramp k mod 256, 1: constant 100
  int unsigned edge_mode = 0;   // 0: pixel ^ A5, 1: zero, 2: one
  int unsigned vlim      = N;   // valids the detector emits per frame
  int unsigned ecnt      = 0;

  int checks = 0;
  int errors = 0;
  int we_cnt, addr_bad, data_bad, rd_cnt_tb, rd_bad, done_cnt;
  int cyc;

  function automatic logic [7:0] img_px(input int unsigned a);
    return (img_mode == 0) ? 8'(a % 256) : 8'd100;
  endfunction

  function automatic logic [7:0] edge_of(input logic [7:0] p);
    case (edge_mode)
      0:       return p ^ 8'hA5;
      1:       return 8'h00;
      default: return 8'h01;
    endcase
  endfunction

  // Image RAM: data one cycle after img_rd.
  always @(posedge clk) if (img_rd) img_data <= img_px(32'(img_addr));

  // Detector: one result per pixel, one cycle after it, up to vlim per frame.
  always @(posedge clk) begin
    if (det_rst) begin
      edge_valid <= 1'b0;
      ecnt       <= 0;
    end else if (ecnt < vlim) begin
      edge_valid <= 1'b1;
      edge_data  <= edge_of(pix_data);
      ecnt       <= ecnt + 1;
    end else begin
      edge_valid <= 1'b0;
    end
  end
  assign edge_busy = ~det_rst;

  // Monitor: result writes must be sequential with the expected data; reads sequential.
  always @(negedge clk) begin
    if (res_we) begin
      if (res_addr != AW'(we_cnt)) addr_bad++;
      if (res_data != edge_of(img_px(we_cnt))) data_bad++;
      we_cnt++;
    end
    if (img_rd) begin
      if (img_addr != AW'(rd_cnt_tb)) rd_bad++;
      rd_cnt_tb++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    we_cnt = 0; addr_bad = 0; data_bad = 0; rd_cnt_tb = 0; rd_bad = 0; done_cnt = 0;
  endtask

  // One-cycle start pulse; returns in the first PREFETCH cycle.
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits for done with a cycle bound; optionally pulses start at cycle inj_at.
  task automatic wait_done(input int inj_at, output int n);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      start = (n == inj_at);
      step();
      n++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    clr_cnt();
    repeat (3) step();
    chk("rst_ctl", 32'({img_rd, img_addr, pix_data, res_we, busy, done, err, det_rst}), 32'h1);
    chk("rst_res", 32'({res_addr, res_data}), 32'h0);
    rst = 1'b0;
    repeat (2) step();

    // Ramp frame, 1024 valids.
    clr_cnt();
    kick();
    chk("t1_first", 32'({busy, img_rd, det_rst, img_addr}), 32'({3'b111, 10'd0}));
    wait_done(-1, cyc);
    chk("t1_latency", 32'(cyc), 32'd1028);
    chk("t1_writes", 32'(we_cnt), 32'd1024);
    chk("t1_addr_seq", 32'(addr_bad), 32'd0);
    chk("t1_data", 32'(data_bad), 32'd0);
    chk("t1_reads", 32'(rd_cnt_tb), 32'd1024);
    chk("t1_rd_seq", 32'(rd_bad), 32'd0);
    chk("t1_busy_err_at_done", 32'({busy, err}), 32'd0);
    step();
    chk("t1_done_pulse", 32'({done, det_rst, done_cnt[3:0]}), 32'({1'b0, 1'b1, 4'd1}));

    // start during STREAM cycle 100 is ignored.
    clr_cnt();
    kick();
    wait_done(102, cyc);
    chk("t2_latency", 32'(cyc), 32'd1028);
    chk("t2_rd_seq", 32'(rd_bad), 32'd0);
    chk("t2_reads", 32'(rd_cnt_tb), 32'd1024);
    repeat (5) step();
    chk("t2_one_done", 32'(done_cnt), 32'd1);
    chk("t2_idle", 32'(busy), 32'd0);

    // Detector stops after 500 results: DRAIN times out.
    clr_cnt();
    vlim = 500;
    kick();
    wait_done(-1, cyc);
    chk("t3_latency", 32'(cyc), 32'd1090);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_writes", 32'(we_cnt), 32'd500);
    chk("t3_addr_seq", 32'(addr_bad), 32'd0);

    // start in DONE ignored; start the cycle after done accepted and clears err.
    start = 1'b1;
    step();
    chk("t5_start_in_done", 32'({busy, err}), 32'({1'b0, 1'b1}));
    chk("t3_no_more_writes", 32'(we_cnt), 32'd500);
    clr_cnt();
    vlim = 1100;                          // extra valids beyond N must be dropped
    step();
    start = 1'b0;
    chk("t5_err_cleared", 32'({busy, err}), 32'({1'b1, 1'b0}));
    wait_done(-1, cyc);
    chk("t5_latency", 32'(cyc), 32'd1028);
    chk("t5_writes_sat", 32'(we_cnt), 32'd1024);
    chk("t5_addr_reuse", 32'(addr_bad), 32'd0);
    chk("t5_err", 32'(err), 32'd0);

    // Reset at STREAM cycle 300 aborts the frame.
    repeat (2) step();
    clr_cnt();
    vlim = N;
    kick();
    repeat (302) step();
    rst = 1'b1;
    step();
    chk("t4_rst_ctl", 32'({img_rd, img_addr, pix_data, res_we, busy, done, err, det_rst}), 32'h1);
    rst = 1'b0;
    repeat (5) step();
    chk("t4_no_done", 32'({done_cnt[7:0], busy}), 32'd0);
    clr_cnt();
    kick();
    chk("t4_restart_addr", 32'({img_rd, img_addr}), 32'({1'b1, 10'd0}));
    wait_done(-1, cyc);
    chk("t4_latency", 32'(cyc), 32'd1028);
    chk("t4_writes", 32'(we_cnt), 32'd1024);
    chk("t4_seq", 32'(rd_bad + addr_bad + data_bad), 32'd0);

`ifdef SEDE_HOST_CHKSUM_EN
    // Constant image with zero edges, then edge=1 per valid.
    repeat (2) step();
    img_mode = 1; edge_mode = 1;
    clr_cnt();
    kick();
    wait_done(-1, cyc);
    chk("t6_chksum_zero", 32'(chksum), 32'd0);
    repeat (2) step();
    edge_mode = 2;
    clr_cnt();
    kick();
    wait_done(-1, cyc);
    chk("t6_chksum_ones", 32'(chksum), 32'd1024);
    chk("t6_data", 32'(data_bad), 32'd0);
    repeat (3) step();
    chk("t6_chksum_hold", 32'(chksum), 32'd1024);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
